ir_xmit: RTL and testbench

NEC-protocol infrared transmitter, the sending counterpart of the IR receiver: serialises a 16-bit address/command word into a standard NEC frame, with optional repeat codes, on a single output pin. Runs on clk27 and drives an IR LED driver or the receiver's input directly for loopback self-test. Framing follows the same NEC definition (leader, LSB-first data with complements, stop mark) the receiver decodes, so a loopback frame reproduces the original ir_code.

---
 rtl/ir_xmit.sv | 150 +++++++++++++++
 tb/tb_ir_xmit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ir_xmit.sv
// NEC infrared transmitter: leader, 32 LSB-first data bits, stop mark, optional repeat codes.
// Define IR_TX_CARRIER_EN to modulate marks with the CARRIER_DIV/CARRIER_HIGH carrier; otherwise ir_tx is the baseband envelope.
module ir_xmit #(
  parameter int UNIT_CYCLES  = 15188,
  parameter int CARRIER_DIV  = 711,
  parameter int CARRIER_HIGH = 237
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic [15:0] ir_code,
  input  logic        ir_code_req,
  input  logic        repeat_en,
  output logic        busy,
  output logic        ir_code_ack,
  output logic        ir_tx
);

  typedef enum logic [3:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK,
    GAP, RPT_MARK, RPT_SPACE, RPT_STOP
  } state_t;

  localparam logic [13:0] UNIT_LAST    = 14'(UNIT_CYCLES - 1);
  localparam logic [7:0]  PERIOD_UNITS = 8'd192;

  state_t      state, state_nxt;
  logic [13:0] cycle_cnt;
  logic [7:0]  period_cnt, period_inc;
  logic [4:0]  unit_cnt, unit_inc, state_units;
  logic [4:0]  bit_idx;
  logic [31:0] shift;
  logic        unit_tick, state_done;

`ifdef IR_TX_CARRIER_EN
  localparam int CW = $clog2(CARRIER_DIV + 1);
  logic [CW-1:0] carrier_cnt, carrier_wrap;

  always_comb begin
    carrier_wrap = (carrier_cnt == CW'(CARRIER_DIV - 1)) ? '0 : carrier_cnt + CW'(1);
  end
`endif

  function automatic logic is_mark(input state_t s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK) ||
           (s == RPT_MARK) || (s == RPT_STOP);
  endfunction

  always_comb begin
    unit_tick  = (state != IDLE) && (cycle_cnt == UNIT_LAST);
    period_inc = period_cnt + 8'd1;
    unit_inc   = unit_cnt + 5'd1;

    case (state)
      LEAD_MARK, RPT_MARK: state_units = 5'd16;
      LEAD_SPACE:          state_units = 5'd8;
      BIT_SPACE:           state_units = shift[0] ? 5'd3 : 5'd1;
      RPT_SPACE:           state_units = 5'd4;
      default:             state_units = 5'd1;
    endcase

    // GAP is timed against the frame period rather than its own length
    if (state == GAP) state_done = unit_tick && (period_inc == PERIOD_UNITS);
    else              state_done = unit_tick && (unit_inc == state_units);

    state_nxt = state;
    if (state == IDLE) begin
      if (ir_code_req) state_nxt = LEAD_MARK;
    end else if (state_done) begin
      case (state)
        LEAD_MARK:  state_nxt = LEAD_SPACE;
        LEAD_SPACE: state_nxt = BIT_MARK;
        BIT_MARK:   state_nxt = BIT_SPACE;
        BIT_SPACE:  state_nxt = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
        STOP_MARK:  state_nxt = GAP;
        GAP:        state_nxt = repeat_en ? RPT_MARK : IDLE;
        RPT_MARK:   state_nxt = RPT_SPACE;
        RPT_SPACE:  state_nxt = RPT_STOP;
        RPT_STOP:   state_nxt = GAP;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cycle_cnt   <= '0;
      period_cnt  <= '0;
      unit_cnt    <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      busy        <= 1'b0;
      ir_code_ack <= 1'b0;
      ir_tx       <= 1'b0;
`ifdef IR_TX_CARRIER_EN
      carrier_cnt <= '0;
`endif
    end else begin
      ir_code_ack <= 1'b0;
      if (state == IDLE) begin
        if (ir_code_req) begin
          state      <= LEAD_MARK;
          shift      <= {~ir_code[7:0], ir_code[7:0], ~ir_code[15:8], ir_code[15:8]};
          cycle_cnt  <= '0;
          period_cnt <= '0;
          unit_cnt   <= '0;
          bit_idx    <= '0;
          busy       <= 1'b1;
          ir_tx      <= 1'b1;
`ifdef IR_TX_CARRIER_EN
          carrier_cnt <= '0;
`endif
        end
      end else begin
        if (unit_tick) begin
          cycle_cnt  <= '0;
          period_cnt <= period_inc;
          unit_cnt   <= unit_inc;
        end else begin
          cycle_cnt <= cycle_cnt + 14'd1;
        end

        if (state_done) begin
          state    <= state_nxt;
          unit_cnt <= '0;
          busy     <= (state_nxt != IDLE);
          ir_tx    <= is_mark(state_nxt);
`ifdef IR_TX_CARRIER_EN
          carrier_cnt <= '0;
`endif
          // Leaving GAP starts a fresh 192-unit period for the next repeat
          if (state == GAP) period_cnt <= '0;
          if (state == BIT_SPACE) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 5'd1;
          end
          if (state == STOP_MARK) ir_code_ack <= 1'b1;
        end else if (is_mark(state)) begin
`ifdef IR_TX_CARRIER_EN
          carrier_cnt <= carrier_wrap;
          ir_tx       <= (carrier_wrap < CW'(CARRIER_HIGH));
`else
          ir_tx <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_ir_xmit.sv
// Directed bench for ir_xmit with a short unit (20 cycles) and a 6-cycle carrier.
// Expected waveforms come from a segment model of the NEC frame built in the bench.
module tb_ir_xmit;

  localparam int U      = 20;
  localparam int MAXLEN = 12000;
`ifdef IR_TX_CARRIER_EN
  localparam bit CARRIER = 1'b1;
`else
  localparam bit CARRIER = 1'b0;
`endif

  logic        clk27 = 1'b0;
  logic        reset_n;
  logic [15:0] ir_code;
  logic        ir_code_req;
  logic        repeat_en;
  logic        busy;
  logic        ir_code_ack;
  logic        ir_tx;

  logic trace_tx   [0:MAXLEN-1];
  logic trace_busy [0:MAXLEN-1];
  logic trace_ack  [0:MAXLEN-1];
  logic exp_tx     [0:MAXLEN-1];
  logic exp_busy   [0:MAXLEN-1];
  logic exp_ack    [0:MAXLEN-1];

  int          n_cmp;
  int          n_fail;
  int          idle_errs;
  int          ack_seen;
  int          stop_at;
  logic [31:0] word;

  ir_xmit #(.UNIT_CYCLES(U), .CARRIER_DIV(6), .CARRIER_HIGH(2)) dut (
    .clk27       (clk27),
    .reset_n     (reset_n),
    .ir_code     (ir_code),
    .ir_code_req (ir_code_req),
    .repeat_en   (repeat_en),
    .busy        (busy),
    .ir_code_ack (ir_code_ack),
    .ir_tx       (ir_tx)
  );

  always #5 clk27 = ~clk27;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples outputs at each falling edge, then drives the next input values.
  task automatic capture(input int n, input int pulse_at, input int hold_at,
                         input int code_at, input logic [15:0] code_val, input int drop_at);
    for (int k = 0; k < n; k++) begin
      trace_tx[k]   = ir_tx;
      trace_busy[k] = busy;
      trace_ack[k]  = ir_code_ack;
      ir_code_req   = (k == pulse_at) || (hold_at >= 0 && k >= hold_at);
      if (k == code_at) ir_code = code_val;
      if (k == drop_at) repeat_en = 1'b0;
      @(negedge clk27);
    end
  endtask

  task automatic add_mark(input int start, input int n);
    for (int k = 0; k < n; k++)
      if (start + k < MAXLEN) exp_tx[start + k] = CARRIER ? ((k % 6) < 2) : 1'b1;
  endtask

  task automatic build_model(input logic [15:0] code, input int nrep);
    logic [31:0] w;
    int p;
    w = {~code[7:0], code[7:0], ~code[15:8], code[15:8]};
    for (int i = 0; i < MAXLEN; i++) begin
      exp_tx[i]   = 1'b0;
      exp_busy[i] = (i < (nrep + 1) * 192 * U);
      exp_ack[i]  = (i == 121 * U);
    end
    add_mark(0, 16 * U);
    p = 24 * U;
    for (int b = 0; b < 32; b++) begin
      add_mark(p, U);
      p = p + U + (w[b] ? 3 * U : U);
    end
    add_mark(p, U);
    for (int r = 1; r <= nrep; r++) begin
      add_mark(r * 192 * U, 16 * U);
      add_mark(r * 192 * U + 20 * U, U);
    end
  endtask

  task automatic compare_trace(input string tag, input int len);
    int m_tx, m_busy, m_ack;
    m_tx = 0; m_busy = 0; m_ack = 0;
    for (int i = 0; i < len; i++) begin
      if (trace_tx[i]   !== exp_tx[i])   m_tx++;
      if (trace_busy[i] !== exp_busy[i]) m_busy++;
      if (trace_ack[i]  !== exp_ack[i])  m_ack++;
    end
    check_output({tag, "_tx_bad_cycles"},   m_tx,   0);
    check_output({tag, "_busy_bad_cycles"}, m_busy, 0);
    check_output({tag, "_ack_bad_cycles"},  m_ack,  0);
  endtask

  // Measures each bit space from the captured trace, the way a receiver would.
  task automatic decode_trace(output logic [31:0] w, output int stop_pos);
    int p, q, j;
    w = '0;
    p = 24 * U;
    for (int b = 0; b < 32; b++) begin
      q = p + U;
      j = q;
      while (j < q + 4 * U && j < MAXLEN - 1 && trace_tx[j] == 1'b0) j++;
      w[b] = ((j - q) > 2 * U);
      p = j;
    end
    stop_pos = p;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset_n = 1'b0; ir_code = '0; ir_code_req = 1'b0; repeat_en = 1'b0;
    repeat (3) @(negedge clk27);
    check_output("reset_tx",   ir_tx,       0);
    check_output("reset_busy", busy,        0);
    check_output("reset_ack",  ir_code_ack, 0);

    $display("[TB] idle with no request");
    reset_n = 1'b1;
    idle_errs = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk27);
      if (ir_tx !== 1'b0 || busy !== 1'b0 || ir_code_ack !== 1'b0) idle_errs++;
    end
    check_output("idle_quiet", idle_errs, 0);

    $display("[TB] frame 0x0408 with busy request pulse, code change and late request");
    ir_code = 16'h0408; ir_code_req = 1'b1;
    @(negedge clk27);
    capture(3841, 1000, 3839, 50, 16'h1234, -1);
    build_model(16'h0408, 0);
    compare_trace("frame1", 3840);
    decode_trace(word, stop_at);
    check_output("frame1_byte0", word[7:0],   32'h04);
    check_output("frame1_byte1", word[15:8],  32'hFB);
    check_output("frame1_byte2", word[23:16], 32'h08);
    check_output("frame1_byte3", word[31:24], 32'hF7);
    check_output("frame1_stop_pos", stop_at, 2400);
    check_output("frame1_ack_2420", trace_ack[2420], 1);
    check_output("frame1_ack_2419", trace_ack[2419], 0);
    check_output("frame1_busy_3839", trace_busy[3839], 1);
    check_output("gap_end_req_busy", trace_busy[3840], 0);
    check_output("gap_end_req_tx",   trace_tx[3840], 0);

    $display("[TB] frame 0x1234 accepted one cycle later, two repeats");
    repeat_en = 1'b1;
    capture(11600, -1, -1, -1, 16'h0000, 8000);
    build_model(16'h1234, 2);
    compare_trace("repeat", 11600);
    check_output("rpt1_mark_start", trace_tx[3840], 1);
    check_output("rpt1_space",      trace_tx[4160], 0);
    check_output("rpt2_mark_start", trace_tx[7680], 1);
    check_output("rpt2_stop_start", trace_tx[8080], 1);
    check_output("rpt_busy_11519",  trace_busy[11519], 1);
    check_output("rpt_busy_11520",  trace_busy[11520], 0);

    $display("[TB] reset during leader");
    ir_code = 16'hC3A5; ir_code_req = 1'b1;
    @(negedge clk27);
    ir_code_req = 1'b0;
    repeat (100) @(negedge clk27);
    check_output("leader_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check_output("async_reset_tx",   ir_tx, 0);
    check_output("async_reset_busy", busy,  0);
    ack_seen = 0;
    repeat (5) begin
      @(negedge clk27);
      if (ir_code_ack !== 1'b0) ack_seen++;
    end
    check_output("reset_no_ack", ack_seen, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk27);
    check_output("post_reset_idle", busy, 0);

    $display("[TB] frame 0x5AA3 after reset");
    ir_code = 16'h5AA3; ir_code_req = 1'b1;
    @(negedge clk27);
    capture(3900, -1, -1, -1, 16'h0000, -1);
    build_model(16'h5AA3, 0);
    compare_trace("after_reset", 3900);
    decode_trace(word, stop_at);
    check_output("after_reset_word", word, 32'h5CA3A55A);
    check_output("after_reset_stop", stop_at, 2400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
